// File: rtl/accum_pkg.sv
// Shared types and default constants for the block accumulator.
package accum_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      REQ     = 2'b01,
      COLLECT = 2'b10,
      DONE    = 2'b11
   } accum_state_t;

   localparam int BLOCK_LEN_DEF = 64;
   localparam int TIMEOUT_DEF   = 16;

endpackage

// File: rtl/block_accumulator_stream_stats.sv
// Sum / maximum / sample-count datapath for one block of streamed values.
// A clear wins over a beat; both are driven by the controlling FSM.
module stream_stats #(
   parameter int WIDTH     = 16,
   parameter int LOGDEPTH  = 6,
   parameter int ACC_WIDTH = WIDTH + LOGDEPTH
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 beat_i,
   input  logic [WIDTH-1:0]     data_i,
   output logic [ACC_WIDTH-1:0] sum_o,
   output logic [WIDTH-1:0]     max_o,
   output logic [LOGDEPTH:0]    count_o
);

   logic [ACC_WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0]     max_q, max_d;
   logic [LOGDEPTH:0]    count_q, count_d;

   // Next-state of the statistics: clear at block start, fold in each accepted beat.
   always_comb begin
      sum_d   = sum_q;
      max_d   = max_q;
      count_d = count_q;
      if (clear_i) begin
         sum_d   = '0;
         max_d   = '0;
         count_d = '0;
      end else if (beat_i) begin
         sum_d   = sum_q + ACC_WIDTH'(data_i);
         if (data_i > max_q) begin
            max_d = data_i;
         end
         count_d = count_q + (LOGDEPTH+1)'(1);
      end
   end

   // Statistics registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sum_q   <= '0;
         max_q   <= '0;
         count_q <= '0;
      end else begin
         sum_q   <= sum_d;
         max_q   <= max_d;
         count_q <= count_d;
      end
   end

   assign sum_o   = sum_q;
   assign max_o   = max_q;
   assign count_o = count_q;

endmodule

// File: rtl/block_accumulator.sv
// Block accumulator: requests one block from the multiplier, gathers the
// streamed values into sum/max/count, and hands the result downstream with a
// valid/ack handshake. A stalled stream ends the block with an error flag.
module block_accumulator
   import accum_pkg::*;
#(
   parameter int LOGDEPTH  = 6,
   parameter int WIDTH     = 16,
   parameter int BLOCK_LEN = BLOCK_LEN_DEF,
   parameter int ACC_WIDTH = WIDTH + LOGDEPTH,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 EN_accum,
   output logic                 RDY_accum,
   output logic                 EN_blockRead,
   input  logic                 VALID_memVal,
   input  logic [WIDTH-1:0]     memVal_data,
   output logic                 VALID_result,
   input  logic                 ACK_result,
   output logic [ACC_WIDTH-1:0] result_sum,
   output logic [WIDTH-1:0]     result_max,
   output logic [LOGDEPTH:0]    result_count,
   output logic                 result_err
);

   localparam int GAP_W = $clog2(TIMEOUT + 1);
   localparam logic [GAP_W-1:0]  TIMEOUT_C   = GAP_W'(TIMEOUT);
   localparam logic [LOGDEPTH:0] BLOCK_LEN_C = (LOGDEPTH+1)'(BLOCK_LEN);

   accum_state_t     state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             err_q, err_d;
   logic             rdy_q, blkRead_q, valid_q;

   logic             statClear;
   logic             statBeat;
   logic             lastBeat;
   logic [LOGDEPTH:0] statCount;

   // Beats only count while the block is being requested or collected.
   assign statClear = (state_q == IDLE) && EN_accum;
   assign statBeat  = VALID_memVal && ((state_q == REQ) || (state_q == COLLECT));
   assign lastBeat  = statBeat && ((statCount + (LOGDEPTH+1)'(1)) == BLOCK_LEN_C);

   stream_stats #(
      .WIDTH     (WIDTH),
      .LOGDEPTH  (LOGDEPTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_stats (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clear_i (statClear),
      .beat_i  (statBeat),
      .data_i  (memVal_data),
      .sum_o   (result_sum),
      .max_o   (result_max),
      .count_o (statCount)
   );

   // Next-state logic: start, wait for the first beat, collect until full or stalled, await ack.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (EN_accum) begin
               state_d = REQ;
               gap_d   = '0;
               err_d   = 1'b0;
            end
         end
         REQ: begin
            if (VALID_memVal) begin
               gap_d   = '0;
               state_d = lastBeat ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (VALID_memVal) begin
               gap_d = '0;
               if (lastBeat) begin
                  state_d = DONE;
               end
            end else begin
               if (gap_q < TIMEOUT_C) begin
                  gap_d = gap_q + GAP_W'(1);
               end
               if (gap_d >= TIMEOUT_C) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end
            end
         end
         DONE: begin
            if (ACK_result) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, gap counter and registered handshake outputs, decoded from the next state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         gap_q     <= '0;
         err_q     <= 1'b0;
         rdy_q     <= 1'b1;
         blkRead_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         err_q     <= err_d;
         rdy_q     <= (state_d == IDLE);
         blkRead_q <= (state_d == REQ);
         valid_q   <= (state_d == DONE);
      end
   end

   assign RDY_accum    = rdy_q;
   assign EN_blockRead = blkRead_q;
   assign VALID_result = valid_q;
   assign result_count = statCount;
   assign result_err   = err_q;

endmodule

// File: tb/tb_block_accumulator.sv
// Scoreboard bench for block_accumulator: stimulus builds a per-cycle stream,
// a reference model derives the expected result, and a monitor checks it.
module tb_block_accumulator;

   localparam int LOGDEPTH  = 6;
   localparam int WIDTH     = 16;
   localparam int BLOCK_LEN = 64;
   localparam int TIMEOUT   = 16;
   localparam int ACC_WIDTH = WIDTH + LOGDEPTH;

   typedef struct {
      logic             v;
      logic [WIDTH-1:0] d;
      logic             en;
      logic             ack;
   } beat_t;

   typedef struct {
      logic [ACC_WIDTH-1:0] sum;
      logic [WIDTH-1:0]     max;
      logic [LOGDEPTH:0]    count;
      logic                 err;
      int                   cycle;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 EN_accum = 1'b0;
   logic                 RDY_accum;
   logic                 EN_blockRead;
   logic                 VALID_memVal = 1'b0;
   logic [WIDTH-1:0]     memVal_data = '0;
   logic                 VALID_result;
   logic                 ACK_result = 1'b0;
   logic [ACC_WIDTH-1:0] result_sum;
   logic [WIDTH-1:0]     result_max;
   logic [LOGDEPTH:0]    result_count;
   logic                 result_err;

   int    nAssert = 0;
   int    nFail   = 0;
   int    cyc     = 0;
   beat_t stim[$];
   exp_t  expQ[$];

   block_accumulator #(
      .LOGDEPTH  (LOGDEPTH),
      .WIDTH     (WIDTH),
      .BLOCK_LEN (BLOCK_LEN),
      .ACC_WIDTH (ACC_WIDTH),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .EN_accum     (EN_accum),
      .RDY_accum    (RDY_accum),
      .EN_blockRead (EN_blockRead),
      .VALID_memVal (VALID_memVal),
      .memVal_data  (memVal_data),
      .VALID_result (VALID_result),
      .ACK_result   (ACK_result),
      .result_sum   (result_sum),
      .result_max   (result_max),
      .result_count (result_count),
      .result_err   (result_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      nAssert++;
      if (act !== expv) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic void addEntry(input logic v, input logic [WIDTH-1:0] d,
                                    input logic en, input logic ack);
      beat_t b;
      b.v = v; b.d = d; b.en = en; b.ack = ack;
      stim.push_back(b);
   endfunction

   // Reference model: walk the per-cycle stream and apply the block rules directly.
   function automatic exp_t modelBlock(input int c0);
      exp_t e;
      int   idle;
      bit   started;
      e.sum = '0; e.max = '0; e.count = '0; e.err = 1'b0; e.cycle = -1;
      idle = 0; started = 0;
      for (int i = 0; i < stim.size(); i++) begin
         if (stim[i].v) begin
            started = 1;
            e.sum   = e.sum + ACC_WIDTH'(stim[i].d);
            if (stim[i].d > e.max) e.max = stim[i].d;
            e.count = e.count + 1'b1;
            idle    = 0;
            if (int'(e.count) == BLOCK_LEN) begin
               e.cycle = c0 + i + 1;
               return e;
            end
         end else if (started) begin
            idle++;
            if (idle == TIMEOUT) begin
               e.err   = 1'b1;
               e.cycle = c0 + i + 1;
               return e;
            end
         end
      end
      return e;
   endfunction

   // Start a block, drive the prepared stream, then complete the handshake.
   task automatic applyStimulus(input int ackDelay);
      exp_t e;
      int   c0;
      bit   seen;
      int   w;
      @(negedge clk);
      EN_accum = 1'b1;
      @(negedge clk);
      EN_accum = 1'b0;
      c0 = cyc;
      e  = modelBlock(c0);
      expQ.push_back(e);
      seen = 0;
      foreach (stim[i]) begin
         if (i > 0) @(negedge clk);
         checkOutput("enBlockRead", EN_blockRead, seen ? 0 : 1);
         checkOutput("rdyBusy", RDY_accum, 0);
         VALID_memVal = stim[i].v;
         memVal_data  = stim[i].d;
         EN_accum     = stim[i].en;
         ACK_result   = stim[i].ack;
         if (stim[i].v) seen = 1;
      end
      @(negedge clk);
      VALID_memVal = 1'b0;
      EN_accum     = 1'b0;
      ACK_result   = 1'b0;
      w = 0;
      while (!VALID_result && w < 5) begin
         @(negedge clk);
         w++;
      end
      checkOutput("resultValid", VALID_result, 1);
      repeat (ackDelay) begin
         checkOutput("rdyHeld", RDY_accum, 0);
         @(negedge clk);
      end
      ACK_result = 1'b1;
      @(negedge clk);
      ACK_result = 1'b0;
      checkOutput("validDrop", VALID_result, 0);
      checkOutput("rdyBack", RDY_accum, 1);
   endtask

   // Monitor: pop on the rising VALID_result, then hold the result stable until it drops.
   exp_t cur;
   bit   inResult = 0;
   always @(negedge clk) begin
      if (VALID_result) begin
         if (!inResult) begin
            inResult = 1;
            if (expQ.size() == 0) begin
               nAssert++;
               nFail++;
               $display("[TB] FAIL unexpectedResult: got valid result, expected none (cycle %0d)", cyc);
               cur.sum = result_sum; cur.max = result_max;
               cur.count = result_count; cur.err = result_err; cur.cycle = cyc;
            end else begin
               cur = expQ.pop_front();
               checkOutput("latency", cyc, cur.cycle);
            end
         end
         checkOutput("sum", 32'(result_sum), 32'(cur.sum));
         checkOutput("max", 32'(result_max), 32'(cur.max));
         checkOutput("count", 32'(result_count), 32'(cur.count));
         checkOutput("err", 32'(result_err), 32'(cur.err));
      end else begin
         inResult = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int nBeats;
      int gap;

      // Reset held for two edges.
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rstRdy", RDY_accum, 1);
      checkOutput("rstEnBlk", EN_blockRead, 0);
      checkOutput("rstValid", VALID_result, 0);
      checkOutput("rstSum", 32'(result_sum), 0);
      checkOutput("rstMax", 32'(result_max), 0);
      checkOutput("rstCount", 32'(result_count), 0);
      checkOutput("rstErr", 32'(result_err), 0);
      rst = 1'b1;

      // Full block of 0..63 after a 10-cycle wait in REQ; ACK on the final beat is ignored.
      stim.delete();
      repeat (10) addEntry(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < BLOCK_LEN; i++) addEntry(1'b1, WIDTH'(i), 1'b0, i == BLOCK_LEN - 1);
      repeat (20) addEntry(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(3);

      // Bubbled stream of maximum values.
      stim.delete();
      for (int i = 0; i < BLOCK_LEN; i++) begin
         addEntry(1'b1, 16'hFFFF, 1'b0, 1'b0);
         repeat (3) addEntry(1'b0, '0, 1'b0, 1'b0);
      end
      repeat (20) addEntry(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(0);

      // Timeout after 10 beats of 5, result held 20 cycles before the ack.
      stim.delete();
      repeat (10) addEntry(1'b1, 16'd5, 1'b0, 1'b0);
      repeat (20) addEntry(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(20);

      // Reset in the middle of collection abandons the block.
      @(negedge clk);
      EN_accum = 1'b1;
      @(negedge clk);
      EN_accum = 1'b0;
      repeat (30) begin
         VALID_memVal = 1'b1;
         memVal_data  = 16'd7;
         @(negedge clk);
      end
      rst = 1'b0;
      VALID_memVal = 1'b0;
      @(negedge clk);
      checkOutput("midRstRdy", RDY_accum, 1);
      checkOutput("midRstEnBlk", EN_blockRead, 0);
      checkOutput("midRstValid", VALID_result, 0);
      checkOutput("midRstSum", 32'(result_sum), 0);
      checkOutput("midRstMax", 32'(result_max), 0);
      checkOutput("midRstCount", 32'(result_count), 0);
      checkOutput("midRstErr", 32'(result_err), 0);
      rst = 1'b1;
      stim.delete();
      repeat (BLOCK_LEN) addEntry(1'b1, 16'd1, 1'b0, 1'b0);
      repeat (20) addEntry(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1);

      // EN_accum toggling during collection, stray beats while DONE.
      stim.delete();
      for (int i = 0; i < BLOCK_LEN; i++) addEntry(1'b1, WIDTH'($urandom), i[0], 1'b0);
      repeat (5) addEntry(1'b1, 16'hFFFF, 1'b1, 1'b0);
      repeat (5) addEntry(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(2);

      // Stray beats in IDLE are ignored.
      for (int i = 0; i < 3; i++) begin
         VALID_memVal = 1'b1;
         memVal_data  = 16'hABCD;
         @(negedge clk);
         checkOutput("idleRdy", RDY_accum, 1);
         checkOutput("idleEnBlk", EN_blockRead, 0);
         checkOutput("idleValid", VALID_result, 0);
      end
      VALID_memVal = 1'b0;

      // Randomized blocks with random gaps, occasional stalls and EN noise.
      for (int b = 0; b < 8; b++) begin
         stim.delete();
         repeat ($urandom_range(0, 5)) addEntry(1'b0, '0, 1'b0, 1'b0);
         nBeats = $urandom_range(1, BLOCK_LEN);
         for (int i = 0; i < nBeats; i++) begin
            addEntry(1'b1, WIDTH'($urandom), 1'($urandom), 1'b0);
            gap = ($urandom_range(0, 15) == 0) ? TIMEOUT + 1 : $urandom_range(0, 3);
            repeat (gap) addEntry(1'b0, '0, 1'($urandom), 1'b0);
         end
         repeat (3) addEntry(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
         repeat (TIMEOUT + 4) addEntry(1'b0, '0, 1'b0, 1'b0);
         applyStimulus($urandom_range(0, 4));
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboardEmpty", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
